// File: rtl/operand_complement_serial_if.sv
// rtl/operand_complement_serial_if.sv - request/result bundle for the serial operand complement stage
//
// Purpose: groups the packed operand word, per-operand modes, start handshake
// and the converted results so the stage connects with a single port.
//
// Signals:
//   nr_coded          packed {first operand, second operand, opcode}
//   mode_first        2-bit mode for the first operand (00/11 pass, 01 negate, 10 absolute)
//   mode_second       2-bit mode for the second operand
//   complement_sel    start request
//   wr_enable         write qualifier for the start request
//   first_nr          converted first operand
//   second_nr         converted second operand
//   operation         captured opcode
//   ovf_first         first conversion overflowed
//   ovf_second        second conversion overflowed
//   busy              conversion in progress
//   complement_finish one-cycle done pulse
//
// Modports: master drives requests and observes results; slave is the stage.

interface operand_complement_serial_if #(
   parameter int WIDTH = 4,
   parameter int OPW   = 4
);
   logic [2*WIDTH+OPW-1:0] nr_coded;
   logic [1:0]             mode_first;
   logic [1:0]             mode_second;
   logic                   complement_sel;
   logic                   wr_enable;
   logic [WIDTH-1:0]       first_nr;
   logic [WIDTH-1:0]       second_nr;
   logic [OPW-1:0]         operation;
   logic                   ovf_first;
   logic                   ovf_second;
   logic                   busy;
   logic                   complement_finish;

   modport master (
      output nr_coded, mode_first, mode_second, complement_sel, wr_enable,
      input  first_nr, second_nr, operation, ovf_first, ovf_second, busy,
             complement_finish
   );

   modport slave (
      input  nr_coded, mode_first, mode_second, complement_sel, wr_enable,
      output first_nr, second_nr, operation, ovf_first, ovf_second, busy,
             complement_finish
   );
endinterface

// File: rtl/operand_complement_serial.sv
// rtl/operand_complement_serial.sv - bit-serial pass/negate/absolute conversion of two packed operands
//
// Purpose: captures {first operand, second operand, opcode}, converts both
// operands LSB first (one bit per clock, in parallel) and presents registered
// results plus the opcode with a one-cycle finish pulse.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   operand_complement_serial_if.slave (request, modes, results, status)
//
// Parameters:
//   WIDTH operand width in bits (>= 2)
//   OPW   opcode width in bits (>= 1)
//
// Optional feature macro: COMPLEMENT_SATURATE_EN
//   defined   -> overflowing negation returns the maximum positive value
//   undefined -> overflowing negation wraps (most negative value returned)
//   overflow flags are raised in both builds.

module operand_complement_serial #(
   parameter int WIDTH = 4,
   parameter int OPW   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   operand_complement_serial_if.slave     bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef COMPLEMENT_SATURATE_EN
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t state, state_nxt;

   // operand shift registers (consumed LSB first) and result shift registers
   // (filled from the MSB end so the final word is aligned after WIDTH shifts)
   logic [WIDTH-1:0] a_sh_f, a_sh_s;
   logic [WIDTH-1:0] r_sh_f, r_sh_s;
   logic             c_f, c_s;
   logic             neg_f, neg_s;
   logic             ovf_pend_f, ovf_pend_s;
   logic [OPW-1:0]   op_q;
   logic [CW-1:0]    bit_idx;

   logic [WIDTH-1:0] first_in, second_in;
   logic             start_ok;
   logic             last_bit;
   logic             bit_f, bit_s;
   logic             c_f_nxt, c_s_nxt;
   logic [WIDTH-1:0] res_f, res_s;

   logic [WIDTH-1:0] first_q, second_q;
   logic [OPW-1:0]   operation_q;
   logic             ovf_first_q, ovf_second_q;
   logic             finish_q;

   assign first_in  = bus.nr_coded[2*WIDTH+OPW-1 -: WIDTH];
   assign second_in = bus.nr_coded[WIDTH+OPW-1 -: WIDTH];

   // absolute value decides pass/negate once, from the sign bit at capture
   function automatic logic resolve_neg(input logic [1:0] mode, input logic msb);
      case (mode)
         2'b01:   resolve_neg = 1'b1;
         2'b10:   resolve_neg = msb;
         default: resolve_neg = 1'b0;
      endcase
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            start_ok = bus.complement_sel & bus.wr_enable;
            if (start_ok) begin
               state_nxt = CONV;
            end
         end
         CONV: begin
            last_bit = (bit_idx == LAST_IDX);
            if (last_bit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------ serial bit arithmetic
   // two's complement negation, serially: invert each bit and ripple a +1
   always_comb begin
      bit_f   = neg_f ? (~a_sh_f[0] ^ c_f) : a_sh_f[0];
      c_f_nxt = ~a_sh_f[0] & c_f;
      bit_s   = neg_s ? (~a_sh_s[0] ^ c_s) : a_sh_s[0];
      c_s_nxt = ~a_sh_s[0] & c_s;
      res_f   = {bit_f, r_sh_f[WIDTH-1:1]};
      res_s   = {bit_s, r_sh_s[WIDTH-1:1]};
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_f     <= '0;
         a_sh_s     <= '0;
         r_sh_f     <= '0;
         r_sh_s     <= '0;
         c_f        <= 1'b0;
         c_s        <= 1'b0;
         neg_f      <= 1'b0;
         neg_s      <= 1'b0;
         ovf_pend_f <= 1'b0;
         ovf_pend_s <= 1'b0;
         op_q       <= '0;
         bit_idx    <= '0;
      end else if (start_ok) begin
         a_sh_f     <= first_in;
         a_sh_s     <= second_in;
         r_sh_f     <= '0;
         r_sh_s     <= '0;
         c_f        <= 1'b1;
         c_s        <= 1'b1;
         neg_f      <= resolve_neg(bus.mode_first, first_in[WIDTH-1]);
         neg_s      <= resolve_neg(bus.mode_second, second_in[WIDTH-1]);
         // only the most negative value has no positive counterpart
         ovf_pend_f <= resolve_neg(bus.mode_first, first_in[WIDTH-1]) &&
                       (first_in == MIN_NEG);
         ovf_pend_s <= resolve_neg(bus.mode_second, second_in[WIDTH-1]) &&
                       (second_in == MIN_NEG);
         op_q       <= bus.nr_coded[OPW-1:0];
         bit_idx    <= '0;
      end else if (state == CONV) begin
         a_sh_f  <= {1'b0, a_sh_f[WIDTH-1:1]};
         a_sh_s  <= {1'b0, a_sh_s[WIDTH-1:1]};
         r_sh_f  <= res_f;
         r_sh_s  <= res_s;
         c_f     <= c_f_nxt;
         c_s     <= c_s_nxt;
         bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
      end
   end

   // -------------------------------------------------- registered results
   // results hold until the next completion; a new start does not clear them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q      <= '0;
         second_q     <= '0;
         operation_q  <= '0;
         ovf_first_q  <= 1'b0;
         ovf_second_q <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         finish_q <= last_bit;
         if (last_bit) begin
            operation_q  <= op_q;
            ovf_first_q  <= ovf_pend_f;
            ovf_second_q <= ovf_pend_s;
`ifdef COMPLEMENT_SATURATE_EN
            first_q      <= ovf_pend_f ? MAX_POS : res_f;
            second_q     <= ovf_pend_s ? MAX_POS : res_s;
`else
            first_q      <= res_f;
            second_q     <= res_s;
`endif
         end
      end
   end

   assign bus.first_nr          = first_q;
   assign bus.second_nr         = second_q;
   assign bus.operation         = operation_q;
   assign bus.ovf_first         = ovf_first_q;
   assign bus.ovf_second        = ovf_second_q;
   assign bus.busy              = (state == CONV);
   assign bus.complement_finish = finish_q;

endmodule

// File: tb/tb_operand_complement_serial.sv
// tb/tb_operand_complement_serial.sv - directed self-checking bench for operand_complement_serial

module tb_operand_complement_serial;

   logic clk;
   logic rst;
   int   tests;
   int   failed;
   int   lat;

   operand_complement_serial_if #(.WIDTH(4), .OPW(4)) bus ();

   operand_complement_serial #(.WIDTH(4), .OPW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef COMPLEMENT_SATURATE_EN
   localparam logic [3:0] OVF_RES = 4'h7;
`else
   localparam logic [3:0] OVF_RES = 4'h8;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive a start at the current negedge; returns at the negedge after the accept edge
   task automatic start(input logic [11:0] nr, input logic [1:0] mf, input logic [1:0] ms);
      bus.nr_coded       = nr;
      bus.mode_first     = mf;
      bus.mode_second    = ms;
      bus.complement_sel = 1'b1;
      bus.wr_enable      = 1'b1;
      @(negedge clk);
      bus.complement_sel = 1'b0;
      bus.wr_enable      = 1'b0;
   endtask

   // count clocks after the accept edge until the finish pulse, bounded
   task automatic wait_finish(output int n);
      n = 0;
      while (bus.complement_finish !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_results(input string tag, input logic [3:0] f, input logic [3:0] s,
                                input logic [3:0] op, input logic of, input logic os);
      check({tag, "_first"}, 32'(bus.first_nr), 32'(f));
      check({tag, "_second"}, 32'(bus.second_nr), 32'(s));
      check({tag, "_op"}, 32'(bus.operation), 32'(op));
      check({tag, "_ovf_first"}, 32'(bus.ovf_first), 32'(of));
      check({tag, "_ovf_second"}, 32'(bus.ovf_second), 32'(os));
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      rst    = 1'b1;
      bus.nr_coded       = '0;
      bus.mode_first     = 2'b00;
      bus.mode_second    = 2'b00;
      bus.complement_sel = 1'b0;
      bus.wr_enable      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_results("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_finish", 32'(bus.complement_finish), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // both negate: -3 = D, -5 = B
      start(12'h35A, 2'b01, 2'b01);
      check("t1_busy", 32'(bus.busy), 32'd1);
      wait_finish(lat);
      check("t1_latency", 32'(lat), 32'd4);
      check_results("t1", 4'hD, 4'hB, 4'hA, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_pulse_one_cycle", 32'(bus.complement_finish), 32'd0);
      check("t1_busy_clear", 32'(bus.busy), 32'd0);

      // both absolute: |-8| overflows, |-1| = 1
      start(12'h8F1, 2'b10, 2'b10);
      wait_finish(lat);
      check("t2_latency", 32'(lat), 32'd4);
      check_results("t2", OVF_RES, 4'h1, 4'h1, 1'b1, 1'b0);
      @(negedge clk);

      // pass / negate zero
      start(12'h602, 2'b00, 2'b01);
      wait_finish(lat);
      check("t3_latency", 32'(lat), 32'd4);
      check_results("t3", 4'h6, 4'h0, 4'h2, 1'b0, 1'b0);
      @(negedge clk);

      // start during CONV is ignored; start in the finish cycle is accepted
      start(12'h35A, 2'b01, 2'b01);
      bus.nr_coded       = 12'h8F1;
      bus.mode_first     = 2'b00;
      bus.mode_second    = 2'b00;
      bus.complement_sel = 1'b1;
      bus.wr_enable      = 1'b1;
      @(negedge clk);
      bus.complement_sel = 1'b0;
      bus.wr_enable      = 1'b0;
      lat = 1;
      while (bus.complement_finish !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("t4_latency", 32'(lat), 32'd4);
      check_results("t4", 4'hD, 4'hB, 4'hA, 1'b0, 1'b0);
      start(12'h8F1, 2'b10, 2'b01);
      check("t4b_busy", 32'(bus.busy), 32'd1);
      check("t4b_finish_low", 32'(bus.complement_finish), 32'd0);
      check("t4b_hold_first", 32'(bus.first_nr), 32'hD);
      wait_finish(lat);
      check("t4b_latency", 32'(lat), 32'd4);
      check_results("t4b", OVF_RES, 4'h1, 4'h1, 1'b1, 1'b0);
      @(negedge clk);

      // select without write enable does nothing
      bus.nr_coded       = 12'h35A;
      bus.mode_first     = 2'b01;
      bus.mode_second    = 2'b01;
      bus.complement_sel = 1'b1;
      bus.wr_enable      = 1'b0;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1 || bus.complement_finish === 1'b1) lat++;
      end
      bus.complement_sel = 1'b0;
      check("t5_no_activity", 32'(lat), 32'd0);
      check("t5_hold_first", 32'(bus.first_nr), 32'(OVF_RES));

      // async reset mid-conversion
      start(12'h35A, 2'b01, 2'b01);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_results("t6_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("t6_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.complement_finish === 1'b1 || bus.busy === 1'b1) lat++;
      end
      check("t6_no_finish", 32'(lat), 32'd0);
      start(12'h602, 2'b00, 2'b01);
      wait_finish(lat);
      check("t6_latency", 32'(lat), 32'd4);
      check_results("t6", 4'h6, 4'h0, 4'h2, 1'b0, 1'b0);
      @(negedge clk);

      // negate positive extreme and pass of most negative (no overflow in pass)
      start(12'h787, 2'b01, 2'b11);
      wait_finish(lat);
      check("t7_latency", 32'(lat), 32'd4);
      check_results("t7", 4'h9, 4'h8, 4'h7, 1'b0, 1'b0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/operand_complement_serial.md
Name: operand_complement_serial

Overview:
- Parametrised successor to the fixed 4-bit two's-complement stage in the calculator datapath.
- Captures a packed word {first operand, second operand, opcode} and converts each operand independently, under a per-operand mode (pass, negate, absolute value).
- Conversion is bit-serial: one bit per clock, both operands in parallel.
- Registered results and the opcode go to the ALU stage, qualified by a one-cycle finish pulse.

Parameters:
- WIDTH, 4, operand width in bits (>= 2).
- OPW, 4, opcode field width in bits (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- nr_coded  in  2*WIDTH+OPW  packed input: [2*WIDTH+OPW-1 : WIDTH+OPW] first operand, [WIDTH+OPW-1 : OPW] second operand, [OPW-1:0] opcode.
- mode_first  in  2  00 pass, 01 negate, 10 absolute, 11 pass.
- mode_second  in  2  same encoding, second operand.
- complement_sel  in  1  start request.
- wr_enable  in  1  write qualifier; a start is accepted only when complement_sel and wr_enable are both high in IDLE.
- first_nr  out  WIDTH  converted first operand.
- second_nr  out  WIDTH  converted second operand.
- operation  out  OPW  captured opcode.
- ovf_first  out  1  first conversion overflowed.
- ovf_second  out  1  second conversion overflowed.
- busy  out  1  high while in CONV.
- complement_finish  out  1  one-cycle done pulse.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state goes to IDLE; bit counter and shift registers clear.
  - first_nr, second_nr, operation, ovf_first, ovf_second, busy and complement_finish all go to 0.
- States: IDLE, CONV.
- IDLE:
  - complement_finish is driven 0 except in the single cycle after a conversion completes.
  - Accept at edge E0 when complement_sel & wr_enable: latch both operands, the opcode and both modes; set each operand's carry to 1; clear bit index; set busy; go to CONV.
  - If complement_sel is high but wr_enable is low, nothing happens.
- Mode resolution at capture: absolute becomes negate if the operand MSB is 1, otherwise pass.
- CONV, edges E1..EWIDTH, bit i = 0..WIDTH-1 (LSB first) per operand:
  - negate: out_i = ~a_i XOR c; c_next = ~a_i AND c.
  - pass: out_i = a_i.
- Edge EWIDTH, the last bit:
  - register first_nr, second_nr and operation.
  - set ovf_x = 1 iff the operand resolved to negate and the input was 1 followed by WIDTH-1 zeros (most negative value).
  - pulse complement_finish = 1 for exactly the cycle after EWIDTH; clear busy; return to IDLE.
- Latency: WIDTH clocks from the accept edge to results and finish.
- Outputs hold their values until the next completion or reset; they are not cleared on a new start.
- Start requests during CONV (busy = 1) are ignored, not queued.
- A start asserted in the same cycle that complement_finish is high is accepted; there is no dead cycle.
- Negating zero gives zero with no overflow.
- Pass mode never flags overflow.
- Opcode is passed through unchanged.

Optional Feature:
- Macro: COMPLEMENT_SATURATE_EN.
- Defined: on overflow, the result is replaced by the maximum positive value (0 followed by WIDTH-1 ones); ovf_x is still flagged.
- Undefined: the result wraps (the most negative value is returned unchanged); ovf_x is flagged.

Test Plan:
- WIDTH=4, OPW=4, nr_coded=0x35A, both modes negate, start: complement_finish high exactly 4 clocks after the accept edge; first_nr=0xD, second_nr=0xB, operation=0xA, ovf=0/0.
- nr_coded=0x8F1, both absolute: first_nr=0x8 (0x7 with COMPLEMENT_SATURATE_EN), ovf_first=1; second_nr=0x1, ovf_second=0; operation=0x1.
- Modes pass/negate, nr_coded=0x602: first_nr=0x6, second_nr=0x0, both ovf=0.
- During CONV, pulse start with a different nr_coded: ignored; results match the first request only; a start aligned with the finish cycle is accepted, with a second finish 4 clocks later.
- complement_sel=1 with wr_enable=0 in IDLE: busy stays 0 and no finish pulse.
- Assert rst after 2 CONV cycles: all outputs go to 0 immediately; no finish pulse; a fresh start after release completes normally.
